// File: rtl/nvio_slot_pkg.sv
// Shared constants and helpers for the fetch-bundle slot-valid tracker.
package nvio_slot_pkg;

  localparam logic VAL = 1'b1;
  localparam logic INV = 1'b0;

  // Widest bundle supported; popcount operates on a zero-extended slot vector.
  localparam int MAX_SLOTS = 8;

  function automatic logic is_cti(input logic jc, input logic ret, input logic tb);
    return jc | ret | tb;
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_SLOTS-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/nvio_first_k_mask.sv
// Selects the k lowest-index set bits of vec; bits beyond the k-th set bit stay clear.
module nvio_first_k_mask
  import nvio_slot_pkg::*;
#(
  parameter int QSLOTS = 3,
  parameter int CW     = $clog2(QSLOTS + 1)
) (
  input  logic [QSLOTS-1:0] vec,
  input  logic [CW-1:0]     k,
  output logic [QSLOTS-1:0] mask
);

  logic [CW:0] taken;

  // Walk from slot 0 upward, granting set bits until k of them are taken.
  always_comb begin
    mask  = '0;
    taken = '0;
    for (int i = 0; i < QSLOTS; i++) begin
      if (vec[i] == VAL && taken < {1'b0, k}) begin
        mask[i] = VAL;
        taken   = taken + {{CW{1'b0}}, 1'b1};
      end else begin
        mask[i] = INV;
      end
    end
  end

endmodule

// File: rtl/slot_valid_n.sv
// Tracks unqueued slots of the current fetch bundle, retires queued slots and
// discards bundles that follow an overriding control transfer.
module slot_valid_n
  import nvio_slot_pkg::*;
#(
  parameter int QSLOTS        = 3,
  parameter int STOMP_BUNDLES = 1,
  parameter int CW            = $clog2(QSLOTS + 1),
  parameter int SW            = $clog2(STOMP_BUNDLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchmiss,
  input  logic              nextb,
  input  logic              phit,
  input  logic [QSLOTS-1:0] ip_mask,
  input  logic [CW-1:0]     queued_cnt,
  input  logic [QSLOTS-1:0] lsm,
  input  logic [QSLOTS-1:0] slot_jc,
  input  logic [QSLOTS-1:0] slot_ret,
  input  logic [QSLOTS-1:0] take_branch,
  input  logic              ip_override,
  output logic [QSLOTS-1:0] slotvd,
  output logic [QSLOTS-1:0] slotv,
  output logic              stomp_next,
  output logic              bundle_done,
  output logic              protocol_err
);

  logic [QSLOTS-1:0]    sel_s;
  logic [QSLOTS-1:0]    cti_s;
  logic [MAX_SLOTS-1:0] vd_ext_s;
  logic [3:0]           k_ext_s;
  logic                 over_s;
  logic                 hold_s;
  logic                 stomp_now_s;
  logic [SW-1:0]        eff_s;
  logic [SW-1:0]        stomp_cnt_r;

  nvio_first_k_mask #(
    .QSLOTS (QSLOTS),
    .CW     (CW)
  ) u_first_k (
    .vec  (slotvd),
    .k    (queued_cnt),
    .mask (sel_s)
  );

  // Retirement, hold, stomp detection and the bundles-to-discard count.
  always_comb begin
    vd_ext_s              = '0;
    vd_ext_s[QSLOTS-1:0]  = slotvd;
    k_ext_s               = 4'(queued_cnt);
    over_s                = (k_ext_s > popcount(vd_ext_s));
    cti_s                 = '0;
    for (int i = 0; i < QSLOTS; i++) begin
      cti_s[i] = is_cti(slot_jc[i], slot_ret[i], take_branch[i]) & sel_s[i];
    end
    hold_s = over_s | (|(sel_s & lsm));
    if (hold_s) begin
      slotv = slotvd;
    end else begin
      slotv = slotvd & ~sel_s;
    end
    stomp_now_s = !hold_s && (|cti_s) && ip_override;
    // A taken redirect kills younger slots even when the queue did not take them.
    if (stomp_now_s) begin
      slotv = '0;
      eff_s = SW'(STOMP_BUNDLES);
    end else begin
      eff_s = stomp_cnt_r;
    end
    stomp_next   = (eff_s != '0);
    bundle_done  = (slotv == '0);
    protocol_err = over_s;
  end

  // Slot-valid and stomp-count state; flush outranks bundle arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotvd      <= '0;
      stomp_cnt_r <= '0;
    end else if (branchmiss) begin
      slotvd      <= '0;
      stomp_cnt_r <= '0;
    end else if (nextb && eff_s != '0) begin
      slotvd      <= '0;
      stomp_cnt_r <= eff_s - SW'(1);
    end else if (nextb) begin
      slotvd      <= ip_mask & {QSLOTS{phit}};
      stomp_cnt_r <= '0;
    end else begin
      slotvd      <= slotv;
      stomp_cnt_r <= eff_s;
    end
  end

endmodule

// File: tb/tb_slot_valid_n.sv
// Bench for slot_valid_n: directed scenarios plus randomized traffic against a
// behavioural model, on one instance with one stomped bundle and one with two.
module tb_slot_valid_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       branchmiss, nextb, phit, ip_override;
  logic [2:0] ip_mask, lsm, slot_jc, slot_ret, take_branch;
  logic [1:0] queued_cnt;

  logic [2:0] slotvd_a, slotv_a, slotvd_b, slotv_b;
  logic       stomp_next_a, bundle_done_a, protocol_err_a;
  logic       stomp_next_b, bundle_done_b, protocol_err_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] m_vd  [2];
  int         m_cnt [2];
  int         m_sb  [2];

  always #5 clk = ~clk;

  slot_valid_n #(.QSLOTS(3), .STOMP_BUNDLES(1)) dut_a (
    .clk(clk), .rst(rst), .branchmiss(branchmiss), .nextb(nextb), .phit(phit),
    .ip_mask(ip_mask), .queued_cnt(queued_cnt), .lsm(lsm), .slot_jc(slot_jc),
    .slot_ret(slot_ret), .take_branch(take_branch), .ip_override(ip_override),
    .slotvd(slotvd_a), .slotv(slotv_a), .stomp_next(stomp_next_a),
    .bundle_done(bundle_done_a), .protocol_err(protocol_err_a)
  );

  slot_valid_n #(.QSLOTS(3), .STOMP_BUNDLES(2)) dut_b (
    .clk(clk), .rst(rst), .branchmiss(branchmiss), .nextb(nextb), .phit(phit),
    .ip_mask(ip_mask), .queued_cnt(queued_cnt), .lsm(lsm), .slot_jc(slot_jc),
    .slot_ret(slot_ret), .take_branch(take_branch), .ip_override(ip_override),
    .slotvd(slotvd_b), .slotv(slotv_b), .stomp_next(stomp_next_b),
    .bundle_done(bundle_done_b), .protocol_err(protocol_err_b)
  );

  // Reference: retire the first k valid slots unless held, then apply the stomp rules.
  task automatic model_eval(input int sb, input logic [2:0] vd, input int cnt,
                            output logic [2:0] e_slotv, output logic e_stomp,
                            output logic e_done, output logic e_perr,
                            output logic [2:0] n_vd, output int n_cnt);
    int k, taken, eff;
    logic [2:0] sel;
    logic hold, snow;
    k = int'(queued_cnt);
    taken = 0;
    sel = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (vd[i] && taken < k) begin
        sel[i] = 1'b1;
        taken++;
      end
    end
    e_perr = (k > $countones(vd));
    hold = e_perr || ((sel & lsm) != 3'b000);
    e_slotv = hold ? vd : (vd & ~sel);
    snow = !hold && (((slot_jc | slot_ret | take_branch) & sel) != 3'b000) && ip_override;
    if (snow) e_slotv = 3'b000;
    eff = snow ? sb : cnt;
    e_stomp = (eff != 0);
    e_done = (e_slotv == 3'b000);
    if (branchmiss) begin
      n_vd = 3'b000; n_cnt = 0;
    end else if (nextb && eff != 0) begin
      n_vd = 3'b000; n_cnt = eff - 1;
    end else if (nextb) begin
      n_vd = phit ? ip_mask : 3'b000; n_cnt = 0;
    end else begin
      n_vd = e_slotv; n_cnt = eff;
    end
  endtask

  task automatic idle();
    branchmiss = 1'b0; nextb = 1'b0; phit = 1'b0; ip_override = 1'b0;
    ip_mask = 3'b000; lsm = 3'b000; slot_jc = 3'b000; slot_ret = 3'b000;
    take_branch = 3'b000; queued_cnt = 2'd0;
  endtask

  // Advance the model at the falling edge, then let the DUT clock and settle.
  task automatic cycle();
    logic [2:0] es, nv;
    logic st, dn, pe;
    int nc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_vd[i] = 3'b000; m_cnt[i] = 0;
      end else begin
        model_eval(m_sb[i], m_vd[i], m_cnt[i], es, st, dn, pe, nv, nc);
        m_vd[i] = nv; m_cnt[i] = nc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_vd[0] = 3'b000; m_vd[1] = 3'b000; m_cnt[0] = 0; m_cnt[1] = 0;
    #2;
    n_checks++;
    if (slotvd_a !== 3'b000 || slotvd_b !== 3'b000)
      $display("FAIL reset_slotvd: got %b/%b want 000", slotvd_a, slotvd_b);
    else n_pass++;
    n_checks++;
    if (slotv_a !== 3'b000 || stomp_next_a !== 1'b0 || bundle_done_a !== 1'b1 || protocol_err_a !== 1'b0)
      $display("FAIL reset_comb: got slotv=%b stomp=%b done=%b err=%b want 000 0 1 0",
               slotv_a, stomp_next_a, bundle_done_a, protocol_err_a);
    else n_pass++;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_retire();
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b111) $display("FAIL retire_load: got %b want 111", slotvd_a);
    else n_pass++;
    idle(); queued_cnt = 2'd1; #1;
    n_checks++;
    if (slotv_a !== 3'b110 || stomp_next_a !== 1'b0)
      $display("FAIL retire_k1: got slotv=%b stomp=%b want 110 0", slotv_a, stomp_next_a);
    else n_pass++;
    cycle();
    queued_cnt = 2'd2; #1;
    n_checks++;
    if (slotv_a !== 3'b000 || bundle_done_a !== 1'b1 || stomp_next_a !== 1'b0)
      $display("FAIL retire_k2: got slotv=%b done=%b stomp=%b want 000 1 0", slotv_a, bundle_done_a, stomp_next_a);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b000) $display("FAIL retire_empty: got %b want 000", slotvd_a);
    else n_pass++;
  endtask

  task automatic test_stomp1();
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    idle(); queued_cnt = 2'd2; slot_jc = 3'b010; ip_override = 1'b1; #1;
    n_checks++;
    if (slotv_a !== 3'b000 || stomp_next_a !== 1'b1)
      $display("FAIL stomp1_kill: got slotv=%b stomp=%b want 000 1", slotv_a, stomp_next_a);
    else n_pass++;
    cycle();
    idle();
    cycle();
    cycle();
    n_checks++;
    if (stomp_next_a !== 1'b1) $display("FAIL stomp1_retained: got %b want 1", stomp_next_a);
    else n_pass++;
    nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b000) $display("FAIL stomp1_dropped: got %b want 000", slotvd_a);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b111) $display("FAIL stomp1_reload: got %b want 111", slotvd_a);
    else n_pass++;
    idle(); queued_cnt = 2'd3;
    cycle();
    idle();
  endtask

  task automatic test_stomp2();
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    idle(); queued_cnt = 2'd1; take_branch = 3'b001; ip_override = 1'b1; #1;
    n_checks++;
    if (slotv_b !== 3'b000 || stomp_next_b !== 1'b1)
      $display("FAIL stomp2_kill: got slotv=%b stomp=%b want 000 1", slotv_b, stomp_next_b);
    else n_pass++;
    cycle();
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    n_checks++;
    if (slotvd_b !== 3'b000 || stomp_next_b !== 1'b1)
      $display("FAIL stomp2_drop1: got slotvd=%b stomp=%b want 000 1", slotvd_b, stomp_next_b);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_b !== 3'b000 || stomp_next_b !== 1'b0)
      $display("FAIL stomp2_drop2: got slotvd=%b stomp=%b want 000 0", slotvd_b, stomp_next_b);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_b !== 3'b111) $display("FAIL stomp2_load3: got %b want 111", slotvd_b);
    else n_pass++;
    idle(); queued_cnt = 2'd3;
    cycle();
    idle();
  endtask

  task automatic test_lsm_perr();
    idle(); nextb = 1'b1; ip_mask = 3'b011; phit = 1'b1;
    cycle();
    idle(); queued_cnt = 2'd1; lsm = 3'b001; #1;
    n_checks++;
    if (slotvd_a !== 3'b011 || slotv_a !== 3'b011)
      $display("FAIL lsm_hold: got slotvd=%b slotv=%b want 011 011", slotvd_a, slotv_a);
    else n_pass++;
    cycle();
    lsm = 3'b000; #1;
    n_checks++;
    if (slotv_a !== 3'b010) $display("FAIL lsm_release: got %b want 010", slotv_a);
    else n_pass++;
    cycle();
    queued_cnt = 2'd2; #1;
    n_checks++;
    if (protocol_err_a !== 1'b1 || slotv_a !== 3'b010)
      $display("FAIL perr_flag: got err=%b slotv=%b want 1 010", protocol_err_a, slotv_a);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b010) $display("FAIL perr_keep: got %b want 010", slotvd_a);
    else n_pass++;
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b0; #1;
    n_checks++;
    if (protocol_err_a !== 1'b0) $display("FAIL perr_k0: got %b want 0", protocol_err_a);
    else n_pass++;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b000) $display("FAIL phit_miss: got %b want 000", slotvd_a);
    else n_pass++;
    idle();
  endtask

  task automatic test_flush_and_async_reset();
    idle(); nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    idle(); queued_cnt = 2'd1; take_branch = 3'b001; ip_override = 1'b1;
    cycle();
    idle(); #1;
    n_checks++;
    if (stomp_next_a !== 1'b1) $display("FAIL flush_pending: got %b want 1", stomp_next_a);
    else n_pass++;
    branchmiss = 1'b1; nextb = 1'b1; ip_mask = 3'b111; phit = 1'b1;
    cycle();
    idle(); #1;
    n_checks++;
    if (slotvd_a !== 3'b000 || stomp_next_a !== 1'b0)
      $display("FAIL flush_clear: got slotvd=%b stomp=%b want 000 0", slotvd_a, stomp_next_a);
    else n_pass++;
    nextb = 1'b1; ip_mask = 3'b101; phit = 1'b1;
    cycle();
    n_checks++;
    if (slotvd_a !== 3'b101) $display("FAIL flush_reload: got %b want 101", slotvd_a);
    else n_pass++;
    idle();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (slotvd_a !== 3'b000 || slotvd_b !== 3'b000)
      $display("FAIL async_reset: got %b/%b want 000", slotvd_a, slotvd_b);
    else n_pass++;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    logic [2:0] es, nv;
    logic st, dn, pe;
    int nc;
    for (int c = 0; c < 400; c++) begin
      idle();
      branchmiss  = ($urandom_range(0, 15) == 0);
      nextb       = bundle_done_a && ($urandom_range(0, 2) != 0);
      phit        = ($urandom_range(0, 7) != 0);
      ip_mask     = 3'($urandom);
      queued_cnt  = 2'($urandom);
      lsm         = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      slot_jc     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      slot_ret    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      take_branch = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      ip_override = ($urandom_range(0, 1) == 0);
      #1;
      model_eval(m_sb[0], m_vd[0], m_cnt[0], es, st, dn, pe, nv, nc);
      n_checks++;
      if (slotv_a !== es || stomp_next_a !== st || bundle_done_a !== dn || protocol_err_a !== pe)
        $display("FAIL rand_a_comb c=%0d: got %b %b %b %b want %b %b %b %b", c,
                 slotv_a, stomp_next_a, bundle_done_a, protocol_err_a, es, st, dn, pe);
      else n_pass++;
      model_eval(m_sb[1], m_vd[1], m_cnt[1], es, st, dn, pe, nv, nc);
      n_checks++;
      if (slotv_b !== es || stomp_next_b !== st || bundle_done_b !== dn || protocol_err_b !== pe)
        $display("FAIL rand_b_comb c=%0d: got %b %b %b %b want %b %b %b %b", c,
                 slotv_b, stomp_next_b, bundle_done_b, protocol_err_b, es, st, dn, pe);
      else n_pass++;
      cycle();
      n_checks++;
      if (slotvd_a !== m_vd[0] || slotvd_b !== m_vd[1])
        $display("FAIL rand_slotvd c=%0d: got %b/%b want %b/%b", c, slotvd_a, slotvd_b, m_vd[0], m_vd[1]);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    m_sb[0] = 1; m_sb[1] = 2;
    test_reset();
    test_retire();
    test_stomp1();
    test_stomp2();
    test_lsm_perr();
    test_flush_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
